// File: rtl/gc_linebuff_nbank.sv
// N-bank rotating scanline buffer: the renderer writes the draw bank while scan-out reads
// the oldest completed bank. Per-pixel occupancy makes unwritten pixels read back as CLEAR_VAL.
module gc_linebuff_nbank #(
  parameter int                BANK_W    = 1,
  parameter int                ADDR_W    = 9,
  parameter int                DATA_W    = 32,
  parameter int                LINE_W    = 320,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              swap_i,
  input  logic              wr_en_i,
  input  logic              wr_first_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              wr_drop_o,
  output logic [BANK_W-1:0] draw_bank_o,
  output logic [BANK_W-1:0] disp_bank_o
);

  localparam int              NBANK    = 2 ** BANK_W;
  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam int              OCC_IW   = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [ADDR_W:0] LINE_LIM = (ADDR_W + 1)'(LINE_W);

  logic [LINE_W-1:0] occ_q [NBANK];
  logic [DATA_W-1:0] mem_q [NBANK*DEPTH];

  logic [BANK_W-1:0] draw_q, draw_d;
  logic [BANK_W-1:0] disp_q, disp_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q;
  logic              wr_drop_q, wr_drop_d;

  logic              wr_in_rng, wr_occ, wr_ok;
  logic [OCC_IW-1:0] wr_idx;
  logic              rd_in_rng, rd_occ;
  logic [OCC_IW-1:0] rd_idx;

  // Pixels at or beyond LINE_W have no occupancy bit; the range test gates every lookup.
  always_comb begin
    wr_in_rng = ({1'b0, wr_addr_i} < LINE_LIM);
    wr_idx    = wr_addr_i[OCC_IW-1:0];
    wr_occ    = wr_in_rng && occ_q[draw_q][wr_idx];
    wr_ok     = wr_en_i && wr_in_rng && !(wr_first_i && wr_occ);
    wr_drop_d = wr_en_i && !wr_ok;

    rd_in_rng = ({1'b0, rd_addr_i} < LINE_LIM);
    rd_idx    = rd_addr_i[OCC_IW-1:0];
    rd_occ    = rd_in_rng && occ_q[disp_q][rd_idx];
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      rd_data_d = rd_occ ? mem_q[{disp_q, rd_addr_i}] : CLEAR_VAL;
    end

    draw_d = draw_q;
    disp_d = disp_q;
    if (swap_i) begin
      draw_d = draw_q + 1'b1;
      disp_d = disp_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      draw_q     <= '0;
      disp_q     <= BANK_W'(1);
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_drop_q  <= 1'b0;
      for (int b = 0; b < NBANK; b++) begin
        occ_q[b] <= '0;
      end
    end else begin
      draw_q     <= draw_d;
      disp_q     <= disp_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en_i;
      wr_drop_q  <= wr_drop_d;
      if (wr_ok) begin
        occ_q[draw_q][wr_idx] <= 1'b1;
      end
      // The bank entering draw duty is never the one being written this cycle (NBANK >= 2).
      if (swap_i) begin
        occ_q[draw_d] <= '0;
      end
    end
  end

  // Pixel storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (wr_ok && !rst_i) begin
      mem_q[{draw_q, wr_addr_i}] <= wr_data_i;
    end
  end

  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign wr_drop_o   = wr_drop_q;
  assign draw_bank_o = draw_q;
  assign disp_bank_o = disp_q;

endmodule

// File: tb/tb_gc_linebuff_nbank.sv
// Bench for gc_linebuff_nbank: a 2-bank instance driven from a vector table and a
// 4-bank instance for rotation; read data is checked through per-instance scoreboard queues.
module tb_gc_linebuff_nbank;

  localparam logic [31:0] CLR = 32'h0;

  typedef struct {
    logic        wr;
    logic        first;
    logic [8:0]  waddr;
    logic [31:0] wdata;
    logic        rd;
    logic [8:0]  raddr;
    logic        sw;
    logic        exp_drop;
    logic [31:0] exp_rd;
    logic [1:0]  exp_draw;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b0, swap_a = 1'b0, wr_en_a = 1'b0, wr_first_a = 1'b0, rd_en_a = 1'b0;
  logic [8:0]  wr_addr_a = '0, rd_addr_a = '0;
  logic [31:0] wr_data_a = '0, rd_data_a;
  logic        rd_valid_a, wr_drop_a;
  logic [0:0]  draw_a, disp_a;

  logic        rst_b = 1'b0, swap_b = 1'b0, wr_en_b = 1'b0, wr_first_b = 1'b0, rd_en_b = 1'b0;
  logic [8:0]  wr_addr_b = '0, rd_addr_b = '0;
  logic [31:0] wr_data_b = '0, rd_data_b;
  logic        rd_valid_b, wr_drop_b;
  logic [1:0]  draw_b, disp_b;

  gc_linebuff_nbank #(.BANK_W(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .swap_i(swap_a), .wr_en_i(wr_en_a), .wr_first_i(wr_first_a),
    .wr_addr_i(wr_addr_a), .wr_data_i(wr_data_a), .rd_en_i(rd_en_a), .rd_addr_i(rd_addr_a),
    .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a), .wr_drop_o(wr_drop_a),
    .draw_bank_o(draw_a), .disp_bank_o(disp_a)
  );

  gc_linebuff_nbank #(.BANK_W(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .swap_i(swap_b), .wr_en_i(wr_en_b), .wr_first_i(wr_first_b),
    .wr_addr_i(wr_addr_b), .wr_data_i(wr_data_b), .rd_en_i(rd_en_b), .rd_addr_i(rd_addr_b),
    .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b), .wr_drop_o(wr_drop_b),
    .draw_bank_o(draw_b), .disp_bank_o(disp_b)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_a[$];
  logic [31:0] sb_b[$];
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic first, input logic [8:0] waddr,
                              input logic [31:0] wdata, input logic rd, input logic [8:0] raddr,
                              input logic sw, input logic exp_drop, input logic [31:0] exp_rd,
                              input logic [1:0] exp_draw);
    vec_t v;
    v.wr = wr; v.first = first; v.waddr = waddr; v.wdata = wdata; v.rd = rd; v.raddr = raddr;
    v.sw = sw; v.exp_drop = exp_drop; v.exp_rd = exp_rd; v.exp_draw = exp_draw;
    return v;
  endfunction

  // One clock of stimulus on instance A (sel_b=0) or B (sel_b=1); outputs sampled 1 time unit after the edge.
  task automatic step(input bit sel_b, input vec_t v);
    int          nb;
    logic [31:0] exp_disp;
    logic [31:0] got;
    nb       = sel_b ? 4 : 2;
    exp_disp = 32'((int'(v.exp_draw) + 1) % nb);
    @(negedge clk);
    if (!sel_b) begin
      rst_a = 1'b0; swap_a = v.sw; wr_en_a = v.wr; wr_first_a = v.first; wr_addr_a = v.waddr;
      wr_data_a = v.wdata; rd_en_a = v.rd; rd_addr_a = v.raddr;
      if (v.rd) sb_a.push_back(v.exp_rd);
    end else begin
      rst_b = 1'b0; swap_b = v.sw; wr_en_b = v.wr; wr_first_b = v.first; wr_addr_b = v.waddr;
      wr_data_b = v.wdata; rd_en_b = v.rd; rd_addr_b = v.raddr;
      if (v.rd) sb_b.push_back(v.exp_rd);
    end
    @(posedge clk);
    #1;
    if (!sel_b) begin
      chk("a_wr_drop", {31'b0, wr_drop_a}, {31'b0, v.exp_drop});
      chk("a_rd_valid", {31'b0, rd_valid_a}, {31'b0, v.rd});
      chk("a_draw_bank", {31'b0, draw_a}, {30'b0, v.exp_draw});
      chk("a_disp_bank", {31'b0, disp_a}, exp_disp);
      if (rd_valid_a) begin
        if (sb_a.size() == 0) begin
          total++; bad++;
          $display("FAIL a_sb_underflow: got rd_valid=1 expected no pending read");
        end else begin
          got = sb_a.pop_front();
          chk("a_rd_data", rd_data_a, got);
        end
      end
    end else begin
      chk("b_wr_drop", {31'b0, wr_drop_b}, {31'b0, v.exp_drop});
      chk("b_rd_valid", {31'b0, rd_valid_b}, {31'b0, v.rd});
      chk("b_draw_bank", {30'b0, draw_b}, {30'b0, v.exp_draw});
      chk("b_disp_bank", {30'b0, disp_b}, exp_disp);
      if (rd_valid_b) begin
        if (sb_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_sb_underflow: got rd_valid=1 expected no pending read");
        end else begin
          got = sb_b.pop_front();
          chk("b_rd_data", rd_data_b, got);
        end
      end
    end
  endtask

  // Reset held for one edge with every other input active; state must return to reset values.
  task automatic do_reset(input bit sel_b);
    @(negedge clk);
    if (!sel_b) begin
      rst_a = 1'b1; swap_a = 1'b1; wr_en_a = 1'b1; wr_first_a = 1'b0; wr_addr_a = 9'd3;
      wr_data_a = 32'hDEAD0003; rd_en_a = 1'b1; rd_addr_a = 9'd3;
      sb_a.delete();
    end else begin
      rst_b = 1'b1; swap_b = 1'b1; wr_en_b = 1'b1; wr_first_b = 1'b0; wr_addr_b = 9'd3;
      wr_data_b = 32'hDEAD0003; rd_en_b = 1'b1; rd_addr_b = 9'd3;
      sb_b.delete();
    end
    @(posedge clk);
    #1;
    if (!sel_b) begin
      chk("a_rst_draw", {31'b0, draw_a}, 32'd0);
      chk("a_rst_disp", {31'b0, disp_a}, 32'd1);
      chk("a_rst_rd_valid", {31'b0, rd_valid_a}, 32'd0);
      chk("a_rst_wr_drop", {31'b0, wr_drop_a}, 32'd0);
      chk("a_rst_rd_data", rd_data_a, 32'd0);
    end else begin
      chk("b_rst_draw", {30'b0, draw_b}, 32'd0);
      chk("b_rst_disp", {30'b0, disp_b}, 32'd1);
      chk("b_rst_rd_valid", {31'b0, rd_valid_b}, 32'd0);
      chk("b_rst_wr_drop", {31'b0, wr_drop_b}, 32'd0);
      chk("b_rst_rd_data", rd_data_b, 32'd0);
    end
  endtask

  initial begin
    // wr first waddr wdata rd raddr sw drop exp_rd draw_after
    vecs.push_back(mk(1, 0, 9'd5,   32'hAABBCCDD, 0, 9'd0,   0, 0, CLR, 0));
    vecs.push_back(mk(1, 0, 9'd7,   32'h11,       0, 9'd0,   0, 0, CLR, 0));
    vecs.push_back(mk(1, 0, 9'd7,   32'h22,       0, 9'd0,   0, 0, CLR, 0));
    vecs.push_back(mk(1, 1, 9'd7,   32'h33,       0, 9'd0,   0, 1, CLR, 0));
    vecs.push_back(mk(1, 0, 9'd320, 32'hBAD1,     0, 9'd0,   0, 1, CLR, 0));
    vecs.push_back(mk(1, 0, 9'd511, 32'hBAD2,     0, 9'd0,   0, 1, CLR, 0));
    vecs.push_back(mk(1, 1, 9'd8,   32'h44,       0, 9'd0,   0, 0, CLR, 0));
    vecs.push_back(mk(0, 0, 9'd0,   32'h0,        0, 9'd0,   1, 0, CLR, 1));
    vecs.push_back(mk(0, 0, 9'd0,   32'h0,        1, 9'd5,   0, 0, 32'hAABBCCDD, 1));
    vecs.push_back(mk(0, 0, 9'd0,   32'h0,        1, 9'd6,   0, 0, CLR, 1));
    vecs.push_back(mk(0, 0, 9'd0,   32'h0,        1, 9'd7,   0, 0, 32'h22, 1));
    vecs.push_back(mk(0, 0, 9'd0,   32'h0,        1, 9'd8,   0, 0, 32'h44, 1));
    vecs.push_back(mk(0, 0, 9'd0,   32'h0,        1, 9'd320, 0, 0, CLR, 1));
    vecs.push_back(mk(0, 0, 9'd0,   32'h0,        1, 9'd511, 0, 0, CLR, 1));
    // write, swap and read in the same cycle all use the pre-swap banks
    vecs.push_back(mk(1, 0, 9'd9,   32'h99,       1, 9'd5,   1, 0, 32'hAABBCCDD, 0));
    vecs.push_back(mk(0, 0, 9'd0,   32'h0,        1, 9'd9,   0, 0, 32'h99, 0));
    vecs.push_back(mk(0, 0, 9'd0,   32'h0,        1, 9'd5,   0, 0, CLR, 0));
    vecs.push_back(mk(0, 0, 9'd0,   32'h0,        0, 9'd0,   1, 0, CLR, 1));
    vecs.push_back(mk(0, 0, 9'd0,   32'h0,        1, 9'd5,   0, 0, CLR, 1));
    vecs.push_back(mk(0, 0, 9'd0,   32'h0,        1, 9'd7,   0, 0, CLR, 1));
    vecs.push_back(mk(0, 0, 9'd0,   32'h0,        0, 9'd0,   1, 0, CLR, 0));
    vecs.push_back(mk(0, 0, 9'd0,   32'h0,        0, 9'd0,   1, 0, CLR, 1));
    vecs.push_back(mk(1, 1, 9'd7,   32'h55,       0, 9'd0,   0, 0, CLR, 1));
    vecs.push_back(mk(1, 1, 9'd7,   32'h66,       0, 9'd0,   0, 1, CLR, 1));
    vecs.push_back(mk(0, 0, 9'd0,   32'h0,        0, 9'd0,   1, 0, CLR, 0));
    vecs.push_back(mk(0, 0, 9'd0,   32'h0,        1, 9'd7,   0, 0, 32'h55, 0));
    vecs.push_back(mk(1, 0, 9'd3,   32'h77,       0, 9'd0,   0, 0, CLR, 0));

    do_reset(1'b0);
    do_reset(1'b1);

    // Freshly reset buffer: every pixel of the display line is transparent.
    for (int x = 0; x < 320; x++) begin
      step(1'b0, mk(0, 0, 9'd0, 32'h0, 1, 9'(x), 0, 0, CLR, 0));
    end
    step(1'b0, mk(0, 0, 9'd0, 32'h0, 0, 9'd0, 0, 0, CLR, 0));
    chk("a_hold_rd_data", rd_data_a, CLR);

    foreach (vecs[i]) step(1'b0, vecs[i]);

    // Reset mid-line (with a write to x=3 just landed), then swap: x=3 must be invisible.
    do_reset(1'b0);
    step(1'b0, mk(0, 0, 9'd0, 32'h0, 0, 9'd0, 1, 0, CLR, 1));
    step(1'b0, mk(0, 0, 9'd0, 32'h0, 1, 9'd3, 0, 0, CLR, 1));
    step(1'b0, mk(0, 0, 9'd0, 32'h0, 0, 9'd0, 1, 0, CLR, 0));
    step(1'b0, mk(0, 0, 9'd0, 32'h0, 1, 9'd3, 0, 0, CLR, 0));

    // Four-bank rotation: data shows up after three swaps, then disappears after a full cycle.
    do_reset(1'b1);
    step(1'b1, mk(1, 0, 9'd4, 32'hB0, 0, 9'd0, 0, 0, CLR, 0));
    step(1'b1, mk(0, 0, 9'd0, 32'h0,  0, 9'd0, 1, 0, CLR, 1));
    step(1'b1, mk(0, 0, 9'd0, 32'h0,  0, 9'd0, 1, 0, CLR, 2));
    step(1'b1, mk(0, 0, 9'd0, 32'h0,  0, 9'd0, 1, 0, CLR, 3));
    step(1'b1, mk(0, 0, 9'd0, 32'h0,  1, 9'd4, 0, 0, 32'hB0, 3));
    step(1'b1, mk(0, 0, 9'd0, 32'h0,  0, 9'd0, 1, 0, CLR, 0));
    step(1'b1, mk(0, 0, 9'd0, 32'h0,  0, 9'd0, 1, 0, CLR, 1));
    step(1'b1, mk(0, 0, 9'd0, 32'h0,  0, 9'd0, 1, 0, CLR, 2));
    step(1'b1, mk(0, 0, 9'd0, 32'h0,  0, 9'd0, 1, 0, CLR, 3));
    step(1'b1, mk(0, 0, 9'd0, 32'h0,  1, 9'd4, 0, 0, CLR, 3));
    step(1'b1, mk(1, 0, 9'd400, 32'h1, 0, 9'd0, 0, 1, CLR, 3));
    step(1'b1, mk(0, 0, 9'd0, 32'h0,  0, 9'd0, 0, 0, CLR, 3));

    chk("a_sb_drained", 32'(sb_a.size()), 32'd0);
    chk("b_sb_drained", 32'(sb_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
